// File: rtl/qix_mbox_pkg.sv
// rtl/qix_mbox_pkg.sv - register map and shared constants for the inter-CPU mailbox
package qix_mbox_pkg;

    localparam logic [2:0] REG_DATA0    = 3'd0;
    localparam logic [2:0] REG_DATA1    = 3'd1;
    localparam logic [2:0] REG_DATA2    = 3'd2;
    localparam logic [2:0] REG_DATA3    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_DOORBELL = 3'd5;
    localparam logic [2:0] REG_MASK     = 3'd6;
    localparam logic [2:0] REG_OVF      = 3'd7;

    // Doorbell write bits and read bits
    localparam int DB_RING   = 0;
    localparam int DB_ACK    = 1;
    localparam int DB_OWN    = 0;
    localparam int DB_REMOTE = 1;

    localparam int MAX_NCH = 4;

endpackage

// File: rtl/qix_mbox_fifo.sv
// rtl/qix_mbox_fifo.sv - show-ahead ring-buffer FIFO for one mailbox channel
module qix_mbox_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);

    // Extra pointer bit distinguishes full from empty
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/qix_cpu_mailbox.sv
// rtl/qix_cpu_mailbox.sv - two-port 6809 mailbox: per-channel FIFOs, doorbell, irq mask, overflow
module qix_cpu_mailbox
    import qix_mbox_pkg::*;
#(
    parameter int         NCH       = 2,
    parameter int         DEPTH     = 4,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] EMPTY_VAL = 8'hFF
) (
    input  logic              clk_20m,
    input  logic              reset_n,
    input  logic              a_e,
    input  logic              a_cs,
    input  logic              a_rnw,
    input  logic [2:0]        a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_nfirq,
    input  logic              b_e,
    input  logic              b_cs,
    input  logic              b_rnw,
    input  logic [2:0]        b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_nfirq
);
    // Index 0 is port A, index 1 is port B
    logic [1:0]        e, cs, rnw, stb, ring, db_flag, nfirq;
    logic [2:0]        addr [2];
    logic [DATA_W-1:0] din  [2];
    logic [DATA_W-1:0] dout [2];

    logic [2*NCH-1:0]  fifo_empty;
    logic [2*NCH-1:0]  fifo_full;
    logic [DATA_W-1:0] fifo_head [2*NCH];

    assign e       = {b_e, a_e};
    assign cs      = {b_cs, a_cs};
    assign rnw     = {b_rnw, a_rnw};
    assign addr[0] = a_addr;
    assign addr[1] = b_addr;
    assign din[0]  = a_din;
    assign din[1]  = b_din;
    assign a_dout  = dout[0];
    assign b_dout  = dout[1];
    assign a_nfirq = nfirq[0];
    assign b_nfirq = nfirq[1];

    // FIFO f carries channel f%NCH from port f/NCH toward the other port
    for (genvar f = 0; f < 2*NCH; f++) begin : g_fifo
        localparam int         SRC  = f / NCH;
        localparam int         DST  = 1 - SRC;
        localparam logic [2:0] SLOT = 3'(f % NCH);

        qix_mbox_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
            .clk   (clk_20m),
            .rst_n (reset_n),
            .push  (stb[SRC] & ~rnw[SRC] & (addr[SRC] == SLOT)),
            .pop   (stb[DST] &  rnw[DST] & (addr[DST] == SLOT)),
            .din   (din[SRC]),
            .head  (fifo_head[f]),
            .empty (fifo_empty[f]),
            .full  (fifo_full[f])
        );
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int R = 1 - p;

        logic               e_prev;
        logic               db;
        logic               nfirq_q;
        logic               wr;
        logic               ack;
        logic [MAX_NCH-1:0] mask;
        logic [MAX_NCH-1:0] ovf;
        logic [MAX_NCH-1:0] in_ne;
        logic [MAX_NCH-1:0] out_full;
        logic [DATA_W-1:0]  rd_data;

        assign stb[p]     = cs[p] & e_prev & ~e[p];
        assign wr         = stb[p] & ~rnw[p];
        assign ring[p]    = wr & (addr[p] == REG_DOORBELL) & din[p][DB_RING];
        assign ack        = wr & (addr[p] == REG_DOORBELL) & din[p][DB_ACK];
        assign db_flag[p] = db;
        assign nfirq[p]   = nfirq_q;
        assign dout[p]    = rd_data;

        always_comb begin
            in_ne    = '0;
            out_full = '0;
            for (int c = 0; c < NCH; c++) begin
                in_ne[c]    = ~fifo_empty[R*NCH + c];
                out_full[c] = fifo_full[p*NCH + c];
            end
        end

        always_comb begin
            rd_data = '0;
            case (addr[p])
                REG_STATUS:   rd_data[7:0] = {out_full, in_ne};
                REG_DOORBELL: begin
                    rd_data[DB_OWN]    = db;
                    rd_data[DB_REMOTE] = db_flag[R];
                end
                REG_MASK:     rd_data[MAX_NCH-1:0] = mask;
                REG_OVF:      rd_data[MAX_NCH-1:0] = ovf;
                default: begin
                    rd_data = DATA_W'(EMPTY_VAL);
                    for (int c = 0; c < NCH; c++) begin
                        if (addr[p] == 3'(c) && in_ne[c]) rd_data = fifo_head[R*NCH + c];
                    end
                end
            endcase
        end

        always_ff @(posedge clk_20m or negedge reset_n) begin
            if (!reset_n) begin
                e_prev  <= 1'b0;
                db      <= 1'b0;
                mask    <= '0;
                ovf     <= '0;
                nfirq_q <= 1'b1;
            end else begin
                e_prev <= e[p];
                // A remote ring beats a local ack so no interrupt is lost
                if (ring[R])      db <= 1'b1;
                else if (ack)     db <= 1'b0;
                if (wr && addr[p] == REG_MASK) mask <= din[p][MAX_NCH-1:0];
                if (wr && addr[p] == REG_OVF)  ovf  <= ovf & ~din[p][MAX_NCH-1:0];
                for (int c = 0; c < NCH; c++) begin
                    if (wr && addr[p] == 3'(c) && fifo_full[p*NCH + c]) ovf[c] <= 1'b1;
                end
                nfirq_q <= ~(db | (|(in_ne & mask)));
            end
        end
    end

endmodule

// File: tb/tb_qix_cpu_mailbox.sv
// tb/tb_qix_cpu_mailbox.sv - directed self-checking bench for qix_cpu_mailbox
module tb_qix_cpu_mailbox;

    logic       clk_20m = 1'b0;
    logic       reset_n;
    logic       a_e, a_cs, a_rnw, a_nfirq;
    logic [2:0] a_addr;
    logic [7:0] a_din, a_dout;
    logic       b_e, b_cs, b_rnw, b_nfirq;
    logic [2:0] b_addr;
    logic [7:0] b_din, b_dout;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] qa, qb;

    always #5 clk_20m = ~clk_20m;

    qix_cpu_mailbox #(.NCH(2), .DEPTH(4), .DATA_W(8), .EMPTY_VAL(8'hFF)) dut (
        .clk_20m (clk_20m),
        .reset_n (reset_n),
        .a_e     (a_e),
        .a_cs    (a_cs),
        .a_rnw   (a_rnw),
        .a_addr  (a_addr),
        .a_din   (a_din),
        .a_dout  (a_dout),
        .a_nfirq (a_nfirq),
        .b_e     (b_e),
        .b_cs    (b_cs),
        .b_rnw   (b_rnw),
        .b_addr  (b_addr),
        .b_din   (b_din),
        .b_dout  (b_dout),
        .b_nfirq (b_nfirq)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One E cycle on either or both ports; read data captured while E is high
    task automatic acc(input logic ae, input logic ard, input logic [2:0] aad, input logic [7:0] ad,
                       input logic be, input logic brd, input logic [2:0] bad, input logic [7:0] bd,
                       output logic [7:0] aq, output logic [7:0] bq);
        @(negedge clk_20m);
        a_cs = ae; a_rnw = ard; a_addr = aad; a_din = ad; a_e = 1'b1;
        b_cs = be; b_rnw = brd; b_addr = bad; b_din = bd; b_e = 1'b1;
        @(negedge clk_20m);
        aq = a_dout; bq = b_dout;
        a_e = 1'b0; b_e = 1'b0;
        @(negedge clk_20m);
        a_cs = 1'b0; b_cs = 1'b0;
    endtask

    task automatic wa(input logic [2:0] ad, input logic [7:0] d);
        logic [7:0] x, y;
        acc(1'b1, 1'b0, ad, d, 1'b0, 1'b0, 3'd0, 8'h00, x, y);
    endtask

    task automatic wb(input logic [2:0] ad, input logic [7:0] d);
        logic [7:0] x, y;
        acc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, ad, d, x, y);
    endtask

    task automatic rb(input logic [2:0] ad, output logic [7:0] q);
        logic [7:0] x;
        acc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, ad, 8'h00, x, q);
    endtask

    task automatic peek_a(input logic [2:0] ad, output logic [7:0] q);
        a_addr = ad; #1; q = a_dout;
    endtask

    task automatic peek_b(input logic [2:0] ad, output logic [7:0] q);
        b_addr = ad; #1; q = b_dout;
    endtask

    initial begin
        // Reset: port B holds E high with a write pending, port A holds E low
        reset_n = 1'b0;
        a_e = 1'b0; a_cs = 1'b1; a_rnw = 1'b0; a_addr = 3'd0; a_din = 8'h77;
        b_e = 1'b1; b_cs = 1'b1; b_rnw = 1'b0; b_addr = 3'd0; b_din = 8'h66;
        repeat (3) @(negedge clk_20m);
        chk("rst_a_nfirq_held", {7'd0, a_nfirq}, 8'h01);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_20m);
        a_cs = 1'b0; b_cs = 1'b0; b_e = 1'b0;
        repeat (2) @(negedge clk_20m);
        chk("rst_a_nfirq", {7'd0, a_nfirq}, 8'h01);
        chk("rst_b_nfirq", {7'd0, b_nfirq}, 8'h01);
        peek_a(3'd4, qa); chk("rst_a_status", qa, 8'h00);
        peek_b(3'd4, qb); chk("rst_b_status", qb, 8'h00);
        peek_a(3'd0, qa); chk("rst_a_data0", qa, 8'hFF);
        peek_b(3'd0, qb); chk("rst_b_data0", qb, 8'hFF);
        peek_a(3'd5, qa); chk("rst_a_doorbell", qa, 8'h00);

        // Fill channel 1 from A, overflow, drain from B
        wa(3'd1, 8'h11); wa(3'd1, 8'h22); wa(3'd1, 8'h33); wa(3'd1, 8'h44);
        peek_b(3'd4, qb); chk("fill_b_status", qb, 8'h02);
        peek_a(3'd4, qa); chk("fill_a_status", qa, 8'h20);
        wa(3'd1, 8'h55);
        peek_a(3'd7, qa); chk("ovf_a", qa, 8'h02);
        rb(3'd1, qb); chk("drain_0", qb, 8'h11);
        rb(3'd1, qb); chk("drain_1", qb, 8'h22);
        rb(3'd1, qb); chk("drain_2", qb, 8'h33);
        rb(3'd1, qb); chk("drain_3", qb, 8'h44);
        rb(3'd1, qb); chk("drain_empty", qb, 8'hFF);
        peek_b(3'd4, qb); chk("drained_b_status", qb, 8'h00);
        wa(3'd7, 8'h02);
        peek_a(3'd7, qa); chk("ovf_clear", qa, 8'h00);

        // Unimplemented slot 2 ignores writes and reads EMPTY_VAL
        wa(3'd2, 8'hEE);
        peek_b(3'd4, qb); chk("slot2_b_status", qb, 8'h00);
        peek_b(3'd2, qb); chk("slot2_b_read", qb, 8'hFF);
        peek_a(3'd7, qa); chk("slot2_a_ovf", qa, 8'h00);

        // Masked inbound-non-empty interrupt timing
        wb(3'd6, 8'h01);
        peek_b(3'd6, qb); chk("b_mask", qb, 8'h01);
        wa(3'd0, 8'hA5);
        chk("irq_1clk_after_push", {7'd0, b_nfirq}, 8'h01);
        @(negedge clk_20m);
        chk("irq_2clk_after_push", {7'd0, b_nfirq}, 8'h00);
        rb(3'd0, qb); chk("irq_read_data", qb, 8'hA5);
        chk("irq_1clk_after_pop", {7'd0, b_nfirq}, 8'h00);
        @(negedge clk_20m);
        chk("irq_2clk_after_pop", {7'd0, b_nfirq}, 8'h01);

        // Doorbell ring, simultaneous ring+ack, final ack
        wa(3'd5, 8'h01);
        chk("ring_1clk", {7'd0, b_nfirq}, 8'h01);
        @(negedge clk_20m);
        chk("ring_2clk", {7'd0, b_nfirq}, 8'h00);
        chk("ring_a_nfirq", {7'd0, a_nfirq}, 8'h01);
        peek_a(3'd5, qa); chk("ring_a_remote", qa, 8'h02);
        peek_b(3'd5, qb); chk("ring_b_own", qb, 8'h01);
        acc(1'b1, 1'b0, 3'd5, 8'h01, 1'b1, 1'b0, 3'd5, 8'h02, qa, qb);
        peek_b(3'd5, qb); chk("ring_vs_ack", qb, 8'h01);
        @(negedge clk_20m);
        chk("ring_vs_ack_irq", {7'd0, b_nfirq}, 8'h00);
        wb(3'd5, 8'h02);
        peek_b(3'd5, qb); chk("ack_b_own", qb, 8'h00);
        peek_a(3'd5, qa); chk("ack_a_remote", qa, 8'h00);
        chk("ack_1clk", {7'd0, b_nfirq}, 8'h00);
        @(negedge clk_20m);
        chk("ack_2clk", {7'd0, b_nfirq}, 8'h01);

        // Full FIFO with concurrent push and pop: push rejected
        wa(3'd1, 8'h61); wa(3'd1, 8'h62); wa(3'd1, 8'h63); wa(3'd1, 8'h64);
        acc(1'b1, 1'b0, 3'd1, 8'h65, 1'b1, 1'b1, 3'd1, 8'h00, qa, qb);
        chk("full_pop_data", qb, 8'h61);
        peek_a(3'd7, qa); chk("full_push_ovf", qa, 8'h02);
        peek_a(3'd4, qa); chk("full_occ3_a_status", qa, 8'h00);
        rb(3'd1, qb); chk("occ3_0", qb, 8'h62);
        rb(3'd1, qb); chk("occ3_1", qb, 8'h63);
        rb(3'd1, qb); chk("occ3_2", qb, 8'h64);
        rb(3'd1, qb); chk("occ3_empty", qb, 8'hFF);
        wa(3'd7, 8'h02);

        // Occupancy 2 with concurrent push/pop across the pointer wrap
        wa(3'd1, 8'h71); wa(3'd1, 8'h72);
        acc(1'b1, 1'b0, 3'd1, 8'h73, 1'b1, 1'b1, 3'd1, 8'h00, qa, qb); chk("wrap_pop0", qb, 8'h71);
        acc(1'b1, 1'b0, 3'd1, 8'h74, 1'b1, 1'b1, 3'd1, 8'h00, qa, qb); chk("wrap_pop1", qb, 8'h72);
        acc(1'b1, 1'b0, 3'd1, 8'h75, 1'b1, 1'b1, 3'd1, 8'h00, qa, qb); chk("wrap_pop2", qb, 8'h73);
        peek_a(3'd4, qa); chk("wrap_a_status", qa, 8'h00);
        peek_a(3'd7, qa); chk("wrap_a_ovf", qa, 8'h00);
        rb(3'd1, qb); chk("wrap_rd0", qb, 8'h74);
        rb(3'd1, qb); chk("wrap_rd1", qb, 8'h75);
        rb(3'd1, qb); chk("wrap_empty", qb, 8'hFF);

        // Asynchronous reset mid-operation
        wa(3'd0, 8'h91); wa(3'd0, 8'h92); wa(3'd0, 8'h93); wa(3'd0, 8'h94); wa(3'd0, 8'h95);
        wa(3'd5, 8'h01);
        @(negedge clk_20m);
        chk("pre_rst_b_nfirq", {7'd0, b_nfirq}, 8'h00);
        b_addr = 3'd4; a_addr = 3'd7;
        #1;
        chk("pre_rst_b_status", b_dout, 8'h01);
        chk("pre_rst_a_ovf", a_dout, 8'h01);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_b_nfirq", {7'd0, b_nfirq}, 8'h00 | 8'h01);
        chk("async_rst_b_status", b_dout, 8'h00);
        chk("async_rst_a_ovf", a_dout, 8'h00);
        @(negedge clk_20m);
        peek_b(3'd5, qb); chk("async_rst_b_db", qb, 8'h00);
        peek_b(3'd6, qb); chk("async_rst_b_mask", qb, 8'h00);
        peek_a(3'd4, qa); chk("async_rst_a_status", qa, 8'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_20m);
        peek_b(3'd0, qb); chk("post_rst_b_data0", qb, 8'hFF);
        chk("post_rst_b_nfirq", {7'd0, b_nfirq}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
